// File: rtl/srl_fifo16_if.sv
// Ready/valid write and read channels of the 16-deep SRL FIFO, plus its status outputs.
// The master side is the producer/consumer; the slave side is the FIFO.
interface srl_fifo16_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [4:0]       count;
   logic             almost_full;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, almost_full
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, almost_full
   );
endinterface

// File: rtl/srl_fifo16.sv
// 16-entry FIFO built on a resetless shift-register array (SRL16E-friendly).
// The head is read at address count-1, so pushes shift and pops only decrement count.
module srl_fifo16 #(
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 12
) (
   input logic        CLK,
   input logic        CLR,
   srl_fifo16_if.slave bus
);

   localparam logic [4:0] DEPTH  = 5'd16;
   localparam logic [4:0] AF_THR = 5'(AF_LEVEL);

   logic             rel_p0;
   logic             rel_p1;
   logic [4:0]       count_q;
   logic [4:0]       count_next;
   logic             af_q;
   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic [3:0]       rd_addr;
   logic [WIDTH-1:0] mem [16];

   assign in_ready  = (count_q != DEPTH);
   assign out_valid = (count_q != 5'd0);

   // Writes are held off until the reset release has passed through both sync flops.
   assign push = bus.in_valid & in_ready & rel_p1;
   assign pop  = out_valid & bus.out_ready;

   always_comb begin
      count_next = count_q;
      unique case ({push, pop})
         2'b10:   count_next = count_q + 5'd1;
         2'b01:   count_next = count_q - 5'd1;
         default: count_next = count_q;
      endcase
   end

   // Reset release synchroniser: asserts asynchronously, releases on CLK.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         rel_p0 <= 1'b0;
         rel_p1 <= 1'b0;
      end else begin
         rel_p0 <= 1'b1;
         rel_p1 <= rel_p0;
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         count_q <= 5'd0;
         af_q    <= 1'b0;
      end else begin
         count_q <= count_next;
         af_q    <= (count_next >= AF_THR);
      end
   end

   // Shift array: no reset so it maps onto shift-register LUT cells.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[0] <= bus.in_data;
         for (int i = 1; i < 16; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign rd_addr = count_q[3:0] - 4'd1;

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.out_data    = mem[rd_addr];
   assign bus.count       = count_q;
   assign bus.almost_full = af_q;

endmodule

// File: tb/tb_srl_fifo16.sv
// Scoreboard bench for srl_fifo16: a queue models FIFO contents and occupancy,
// words are pushed on accepted writes and popped/compared on accepted reads.
module tb_srl_fifo16;

   localparam int WIDTH = 8;
   localparam int AF    = 12;

   logic CLK = 1'b0;
   logic CLR = 1'b0;
   logic gate = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] sb [$];

   srl_fifo16_if #(.WIDTH(WIDTH)) bus ();

   srl_fifo16 #(.WIDTH(WIDTH), .AF_LEVEL(AF)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a falling edge: drives one cycle of stimulus, checks the
   // combinational and registered outputs against the model, then advances a cycle.
   task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
      logic do_push;
      logic do_pop;
      int   n;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      #1;
      n = sb.size();
      check("count", 32'(bus.count), n);
      check("almost_full", 32'(bus.almost_full), 32'(n >= AF));
      check("in_ready", 32'(bus.in_ready), 32'(n != 16));
      check("out_valid", 32'(bus.out_valid), 32'(n != 0));
      if (n != 0) check("out_data", 32'(bus.out_data), 32'(sb[0]));
      do_pop  = ordy && (n != 0);
      do_push = iv && (n != 16) && !gate;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(d);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic release_clr();
      CLR  = 1'b1;
      gate = 1'b1;
      step(1'b1, 8'h77, 1'b0);
      gate = 1'b0;
      step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain();
      while (sb.size() != 0) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      @(negedge CLK);
      #1;
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_almost_full", 32'(bus.almost_full), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge CLK);
      release_clr();

      // Three pushes then three pops.
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Fill to 16, drop a 17th write, drain in order.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'h99, 1'b0);
      drain();

      // Full with write and read together: read only.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      drain();

      // Steady state at five words with continuous push and pop.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b1);
      drain();

      // Read request while empty alongside a write.
      step(1'b1, 8'hA5, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      drain();

      // Random handshakes: fill-biased, then drain-biased.
      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      drain();

      // Asynchronous reset at nine words, asserted between edges.
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      bus.in_valid = 1'b0;
      #2;
      CLR = 1'b0;
      #1;
      check("clr_count", 32'(bus.count), 32'd0);
      check("clr_out_valid", 32'(bus.out_valid), 32'd0);
      check("clr_almost_full", 32'(bus.almost_full), 32'd0);
      check("clr_in_ready", 32'(bus.in_ready), 32'd1);
      sb.delete();
      @(posedge CLK);
      @(negedge CLK);
      release_clr();
      step(1'b1, 8'h3C, 1'b0);
      step(1'b1, 8'h4D, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/srl_fifo16.md
SRL_FIFO16 -- requirements
Module: srl_fifo16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (1..64).
REQ-002 The block SHALL have parameter AF_LEVEL, default 12, giving the occupancy at or above which almost_full asserts (1..16).
REQ-003 The block SHALL have port CLK, input, 1, clock; all state updates on rising edge.
REQ-004 The block SHALL have port CLR, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, write request.
REQ-006 The block SHALL have port in_ready, output, 1, FIFO can accept a word.
REQ-007 The block SHALL have port in_data, input, WIDTH, write data.
REQ-008 The block SHALL have port out_valid, output, 1, head word available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer takes the head word.
REQ-010 The block SHALL have port out_data, output, WIDTH, head (oldest) word.
REQ-011 The block SHALL have port count, output, 5, current occupancy 0..16.
REQ-012 The block SHALL have port almost_full, output, 1, registered flag, count >= AF_LEVEL.

Function
REQ-013 Storage SHALL be a 16-entry x WIDTH shift-register array with no reset, so it maps onto SRL16E-style cells: on push, entry[0] <= in_data and entry[i] <= entry[i-1] for i = 1..15.
REQ-014 push SHALL equal in_valid & in_ready; pop SHALL equal out_valid & out_ready.
REQ-015 in_ready SHALL equal (count != 16) and SHALL NOT depend combinationally on out_ready.
REQ-016 out_valid SHALL equal (count != 0).
REQ-017 out_data SHALL equal entry[count-1] combinationally (read address = count-1, 4 bits) whenever out_valid = 1; it is unchecked when out_valid = 0.
REQ-018 count SHALL update as follows: push only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-019 On simultaneous push and pop, the array SHALL shift and count SHALL hold, so that out_data in the next cycle is the previous second-oldest word.
REQ-020 When full (count = 16), in_valid SHALL be ignored even if out_ready = 1 in the same cycle: no shift occurs, the pop proceeds, and count becomes 15.
REQ-021 When empty (count = 0), out_ready SHALL be ignored and count SHALL NOT underflow; a push makes out_valid = 1 in the next cycle with out_data = that word (write-to-read latency 1 cycle).
REQ-022 almost_full SHALL be registered: next value = (next count >= AF_LEVEL), with no combinational lag versus count.
REQ-023 Word order SHALL be strictly first-in first-out, with no loss or duplication under any handshake pattern.

Reset
REQ-024 While CLR = 0, count SHALL be 0, almost_full 0, out_valid 0 and in_ready 1, asynchronously and independent of CLK.
REQ-025 CLR deassertion SHALL be synchronised to CLK internally (2-flop release) so the first push is accepted no earlier than the 2nd rising edge after CLR rises.
REQ-026 Assertion of CLR mid-operation SHALL discard all stored words: count = 0 immediately, array contents are left as-is but are unreachable.

Verification
REQ-027 The bench SHALL cover: after reset, push 0x11, 0x22, 0x33 on consecutive cycles with out_ready = 0 -> count = 3, out_data = 0x11; then out_ready = 1 for 3 cycles -> outputs 0x11, 0x22, 0x33, then count = 0 and out_valid = 0.
REQ-028 The bench SHALL cover: push 16 words 0x00..0x0F -> in_ready = 0 and count = 16; almost_full = 1 from the cycle count reaches 12; a 17th in_valid is dropped, and the drain returns exactly 0x00..0x0F.
REQ-029 The bench SHALL cover: at count = 16, in_valid = 1 with out_ready = 1 -> head popped, no write, count = 15, in_ready = 1 the next cycle.
REQ-030 The bench SHALL cover: count = 5 with continuous push and pop for 20 cycles -> count stays 5 and the output sequence equals the input sequence delayed by 5 words.
REQ-031 The bench SHALL cover: at count = 0, out_ready = 1 with in_valid = 1 (0xA5) -> no pop that cycle, count = 1 and out_data = 0xA5 the next cycle.
REQ-032 The bench SHALL cover: drive CLR low at count = 9 between clock edges -> count = 0, out_valid = 0 and almost_full = 0 before the next edge; after release, the first pushed word reads back first.
